// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave front end.
// Optional feature macro: SPI_SLAVE_TX_TIMEOUT_EN (read-byte wait timeout).
package spi_pkg;

  localparam int RX_W_DEF       = 10;
  localparam int TX_W_DEF       = 8;
  localparam int TX_TIMEOUT_DEF = 16;

  // RAM command encodings carried in rx_data[9:8]; the slave itself only looks at bit 9.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side word/byte handshake, grouped for the slave front end.
// Optional feature macro: SPI_SLAVE_TX_TIMEOUT_EN (drives tx_timeout when defined).
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int RX_W = RX_W_DEF,
  parameter int TX_W = TX_W_DEF
);
  logic            MOSI;
  logic            SS_n;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;
  logic            tx_timeout;

  modport slave (
    input  MOSI, SS_n, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, tx_timeout
  );

  modport master (
    output MOSI, SS_n, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, tx_timeout
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// Shifts one RAM read byte out on MISO, MSB first; owns the read-wait timeout counter
// when SPI_SLAVE_TX_TIMEOUT_EN is defined.
module spi_tx_serializer #(
  parameter int TX_W = 8
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  , parameter int TX_TIMEOUT = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [TX_W-1:0] data_i,
  input  logic            abort_i,
  output logic            miso_o,
  output logic            busy_o
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  , input  logic          wait_i,
  output logic            fire_o,
  output logic            timeout_o
`endif
);
  localparam int CW = $clog2(TX_W);
  localparam logic [CW-1:0] LAST = CW'(TX_W - 1);

  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic [TX_W-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // cnt holds the number of bits still to drive after the one currently on MISO.
  always_comb begin
    miso_d = miso_q;
    busy_d = busy_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    if (abort_i) begin
      miso_d = 1'b0;
      busy_d = 1'b0;
      sh_d   = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      miso_d = data_i[TX_W-1];
      sh_d   = {data_i[TX_W-2:0], 1'b0};
      cnt_d  = LAST;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        miso_d = 1'b0;
        busy_d = 1'b0;
      end else begin
        miso_d = sh_q[TX_W-1];
        sh_d   = {sh_q[TX_W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
      busy_q <= 1'b0;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else begin
      miso_q <= miso_d;
      busy_q <= busy_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
    end
  end

  assign miso_o = miso_q;
  assign busy_o = busy_q;

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  localparam int TW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TX_TIMEOUT - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  // A tx_valid on the final allowed edge still wins over the timeout.
  assign fire_o = wait_i && !load_i && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d  = wait_i ? to_cnt_q + 1'b1 : '0;
    timeout_d = fire_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserializes 10-bit command words for the RAM and returns read bytes.
// Optional feature macro: SPI_SLAVE_TX_TIMEOUT_EN (abort a read-data wait after TX_TIMEOUT cycles).
module spi_slave
  import spi_pkg::*;
#(
  parameter int RX_W = RX_W_DEF,
  parameter int TX_W = TX_W_DEF
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  , parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
`endif
) (
  input logic       clk,
  input logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(RX_W + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(RX_W - 1);
  localparam logic [CW-1:0] BIT_DONE = CW'(RX_W);

  spi_state_e      state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RX_W-2:0] rx_sh_q, rx_sh_d;
  logic [RX_W-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_addr_flag_q, rd_addr_flag_d;
  logic            tx_done_q, tx_done_d;

  logic sample, tx_wait, tx_load, tx_fire, tx_busy;

  assign sample  = (state_q != IDLE) && (bit_cnt_q != BIT_DONE);
  // Only the post-completion READ_DATA wait listens to tx_valid, and only once per frame.
  assign tx_wait = (state_q == READ_DATA) && (bit_cnt_q == BIT_DONE) && !tx_done_q
                   && !tx_busy && !bus.SS_n;
  assign tx_load = tx_wait && bus.tx_valid;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sh_d        = rx_sh_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_done_d      = tx_done_q;

    if (sample) begin
      rx_sh_d   = {rx_sh_q[RX_W-3:0], bus.MOSI};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == BIT_LAST) begin
        rx_data_d  = {rx_sh_q, bus.MOSI};
        rx_valid_d = 1'b1;
        if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
      end
    end

    if (state_q == CHK_CMD) begin
      if (bus.MOSI == CMD_RD_ADDR[1]) state_d = rd_addr_flag_q ? READ_DATA : READ_ADD;
      else                            state_d = WRITE;
    end

    if (tx_load || tx_fire) begin
      rd_addr_flag_d = 1'b0;
      tx_done_d      = 1'b1;
    end

    if (state_q == IDLE) begin
      bit_cnt_d = '0;
      rx_sh_d   = '0;
      tx_done_d = 1'b0;
      if (!bus.SS_n) state_d = CHK_CMD;
    end else if (bus.SS_n) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sh_q        <= rx_sh_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_done_q      <= tx_done_d;
    end
  end

  spi_tx_serializer #(
    .TX_W       (TX_W)
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    , .TX_TIMEOUT (TX_TIMEOUT)
`endif
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tx_load),
    .data_i  (bus.tx_data),
    .abort_i (bus.SS_n),
    .miso_o  (bus.MISO),
    .busy_o  (tx_busy)
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    , .wait_i    (tx_wait),
    .fire_o    (tx_fire),
    .timeout_o (bus.tx_timeout)
`endif
  );

`ifndef SPI_SLAVE_TX_TIMEOUT_EN
  assign tx_fire        = 1'b0;
  assign bus.tx_timeout = 1'b0;
`endif

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM block.
- Deserializes 10-bit command/data words from MOSI while SS_n is low and presents each completed word to the RAM as rx_data with a one-cycle rx_valid pulse.
- For read-data commands, waits for the RAM's tx_valid/tx_data response and serializes the 8-bit byte back on MISO, MSB first.
- SPI sampling is synchronous to the single system clock.

Parameters:
- RX_W, 10, width of received word: 2 command bits plus 8 address/data bits.
- TX_W, 8, width of the RAM read byte shifted out on MISO.
- TX_TIMEOUT, 16, cycles to wait for tx_valid before abort; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- MOSI  input  1  serial data from master, sampled on clk rising edge.
- SS_n  input  1  active-low slave select; high aborts or ends a frame.
- MISO  output  1  serial read data to master, registered.
- rx_data  output  RX_W  last completed word, {cmd[1:0], payload[7:0]}.
- rx_valid  output  1  one-cycle pulse; rx_data is valid.
- tx_data  input  TX_W  read byte from RAM.
- tx_valid  input  1  RAM read byte valid.
- tx_timeout  output  1  one-cycle abort pulse; tied 0 without the macro.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE, MISO=0, rx_data=0, rx_valid=0, tx_timeout=0.
  - Bit counter=0, rd_addr_flag=0, shift registers cleared.
  - Reset mid-frame discards any partial word.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: at edge k with SS_n=0, go to CHK_CMD. Otherwise remain in IDLE.
- Frame sampling: edges k+1..k+10 sample MOSI into rx bits 9..0, MSB first.
  - Edge k+1 is taken in CHK_CMD.
  - Edges k+2..k+10 are taken in the command state.
- CHK_CMD: MOSI bit 9 selects the next state.
  - bit9=0 -> WRITE.
  - bit9=1 with rd_addr_flag=0 -> READ_ADD.
  - bit9=1 with rd_addr_flag=1 -> READ_DATA.
- Word completion, at edge k+10:
  - rx_data updates and rx_valid=1 for exactly the following cycle.
  - rx_data holds its value until the next completed word.
- WRITE: after completion, further MOSI bits are ignored until SS_n=1.
- READ_ADD: after completion, set rd_addr_flag=1, then wait for SS_n=1.
- READ_DATA:
  - After completion, wait for tx_valid.
  - At the first edge m with tx_valid=1, latch tx_data and set MISO=tx_data[7] after edge m.
  - Edges m+1..m+7 drive bits 6..0. After edge m+8, MISO=0.
  - rd_addr_flag clears at edge m.
  - Further tx_valid pulses in the same frame are ignored.
- tx_valid is ignored in every state and phase except READ_DATA waiting.
- MISO is 0 whenever no byte is being shifted.
- SS_n=1 sampled in any non-IDLE state:
  - Next state is IDLE; counters are cleared.
  - No rx_valid for a partial word; a byte in progress on MISO is truncated and MISO returns to 0.
  - rd_addr_flag is kept.
- Simultaneous SS_n=1 with the 10th bit: the word completes and rx_valid pulses, then IDLE.
- rx_data[9:8] is passed through verbatim; the RAM decodes it. The slave uses only bit 9 plus rd_addr_flag.

Optional Feature:
- Macro: SPI_SLAVE_TX_TIMEOUT_EN.
- Defined: a counter starts at READ_DATA word completion. If tx_valid is not seen within TX_TIMEOUT cycles:
  - tx_timeout pulses for one cycle.
  - MISO stays 0.
  - rd_addr_flag clears.
  - State waits for SS_n=1.
- Not defined: waits indefinitely; tx_timeout is constant 0 and no counter logic is present.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_e (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - RX_W/TX_W defaults.
- One sub-module: spi_tx_serializer (load, byte in, MISO out, busy). It also owns the optional timeout counter.

Test Plan:
- Reset: hold rst_n=0 for 1 cycle mid-frame -> MISO=0, rx_valid=0, rx_data=10'h000; next frame 10'b00_1010_1010 -> rx_data=10'h0AA with a single rx_valid pulse 11 edges after SS_n fall is sampled.
- Write sequence: frames 10'b00_0000_0101 then 10'b01_1111_0000 -> two rx_valid pulses, rx_data 10'h005 then 10'h1F0, MISO stays 0.
- Read: frame 10'b10_0000_0010 (flag sets) then 10'b11_0000_0010; bench returns tx_valid with 8'h33 two cycles after rx_valid -> MISO sequence 0,0,1,1,0,0,1,1, then 0, and flag cleared.
- Read-data with flag=0: frame 10'b11_0000_0010 -> treated as READ_ADD: rx_valid with 10'h302, no MISO activity, flag=1.
- Abort: SS_n=1 after 5 bits -> no rx_valid, state IDLE; following full frame 10'b00_0000_0001 -> rx_data=10'h001.
- With SPI_SLAVE_TX_TIMEOUT_EN: read-data frame with no tx_valid for 16 cycles -> one tx_timeout pulse, MISO=0, flag cleared; a later tx_valid in the same frame is ignored.
